pe_accumulator: RTL

Accumulation stage placed directly downstream of the 8x8 pipelined multiplier in each systolic-array processing element. It consumes the multiplier's 16-bit `result`/`done` pair and sums a programmed number of products into one dot-product term. It then presents the sum with a one-cycle valid pulse to the array output collector. A start/busy handshake lets the controller launch, abort, and re-launch jobs.

---
 rtl/pe_accumulator.sv | 91 +++++++++
 1 files changed

// File: rtl/pe_accumulator.sv
// Dot-product accumulation stage behind the PE multiplier. It sums a programmed
// number of 16-bit products and emits the sum with a one-cycle valid pulse.
module pe_accumulator #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  input  logic [15:0]      prod,
  input  logic             prod_valid,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  output logic             overflow,
  output logic             busy,
  output logic [CNT_W-1:0] terms_left
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum_ext;

  // The extra top bit of the widened add is the carry that feeds the sticky overflow flag.
  assign sum_ext = {1'b0, acc} + {{(ACC_W-15){1'b0}}, prod};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      acc_out    <= '0;
      acc_valid  <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      terms_left <= '0;
    end else begin
      acc_valid <= 1'b0;
      // A start wins in every state: it aborts an ACCUM job or chains on from EMIT.
      if (start) begin
        acc        <= '0;
        overflow   <= 1'b0;
        terms_left <= num_terms;
        busy       <= 1'b1;
        if (num_terms == '0) begin
          acc_out   <= '0;
          acc_valid <= 1'b1;
          state     <= EMIT;
        end else begin
          state <= ACCUM;
        end
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          ACCUM: begin
            if (prod_valid) begin
              acc        <= sum_ext[ACC_W-1:0];
              terms_left <= terms_left - ONE;
              if (sum_ext[ACC_W]) begin
                overflow <= 1'b1;
              end
              if (terms_left == ONE) begin
                acc_out   <= sum_ext[ACC_W-1:0];
                acc_valid <= 1'b1;
                state     <= EMIT;
              end
            end
          end
          EMIT: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
